// File: rtl/vedicmult_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
// The magnitude/negate helpers are only referenced when VEDICMULT_SIGNED_EN is defined.
package vedicmult_pkg;

    // Number of register stages between operand acceptance and result.
    localparam int unsigned LAT  = 3;

    // Widest vector the helpers handle (covers a 2*WIDTH product up to WIDTH = 64).
    localparam int unsigned MAXW = 128;

    // Operand width must be a power of two and at least 4.
    function automatic bit width_ok(input int unsigned w);
        return (w >= 4) && ((w & (w - 1)) == 0);
    endfunction

    // All-ones mask covering the low w bits.
    function automatic logic [MAXW-1:0] lowmask(input int unsigned w);
        return {MAXW{1'b1}} >> (MAXW - w);
    endfunction

    // Two's-complement negation of the low w bits of x.
    function automatic logic [MAXW-1:0] negate(input logic [MAXW-1:0] x, input int unsigned w);
        return (~x + MAXW'(1)) & lowmask(w);
    endfunction

    // Magnitude of a w-bit two's-complement value; the most-negative value
    // maps to 2^(w-1), which is still representable as unsigned.
    function automatic logic [MAXW-1:0] mag(input logic [MAXW-1:0] x, input int unsigned w);
        return x[w-1] ? negate(x, w) : (x & lowmask(w));
    endfunction

endpackage

// File: rtl/vedicmult_core.sv
// Recursive combinational Urdhva-Tiryagbhyam multiplier.
// WIDTH = 2 is the base case; wider instances split into four half-width products.
module vedicmult_core
    import vedicmult_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned H = WIDTH / 2;

    if (WIDTH == 2) begin : g_base
        // 2-bit vertical-and-crosswise product
        always_comb begin
            logic c1;
            c1   = (a[1] & b[0]) & (a[0] & b[1]);
            p    = '0;
            p[0] = a[0] & b[0];
            p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
            p[2] = (a[1] & b[1]) ^ c1;
            p[3] = (a[1] & b[1]) & c1;
        end
    end else begin : g_rec
        logic [WIDTH-1:0] pll, plh, phl, phh;
        logic [WIDTH:0]   mid;

        vedicmult_core #(.WIDTH(H)) u_ll (.a(a[H-1:0]),     .b(b[H-1:0]),     .p(pll));
        vedicmult_core #(.WIDTH(H)) u_lh (.a(a[H-1:0]),     .b(b[WIDTH-1:H]), .p(plh));
        vedicmult_core #(.WIDTH(H)) u_hl (.a(a[WIDTH-1:H]), .b(b[H-1:0]),     .p(phl));
        vedicmult_core #(.WIDTH(H)) u_hh (.a(a[WIDTH-1:H]), .b(b[WIDTH-1:H]), .p(phh));

        // Recombine: outer products concatenated, crosswise sum shifted by H
        always_comb begin
            mid = {1'b0, plh} + {1'b0, phl};
            p   = {phh, pll} + ({{(WIDTH-1){1'b0}}, mid} << H);
        end
    end

endmodule

// File: rtl/vedicmult_pipe.sv
// Three-stage pipelined Vedic multiplier with valid/ready on both sides.
// Optional macro VEDICMULT_SIGNED_EN adds the in_sgn port and a signed mode
// (magnitudes multiplied, sign carried alongside valid, result negated in S3).
module vedicmult_pipe
    import vedicmult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef VEDICMULT_SIGNED_EN
    input  logic                 in_sgn,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned H = WIDTH / 2;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("vedicmult_pipe: WIDTH must be a power of two and >= 4");
    end

    logic en;

    logic [WIDTH-1:0] a_op, b_op;
    logic [WIDTH-1:0] pll_c, plh_c, phl_c, phh_c;

    logic [WIDTH-1:0] pll1, plh1, phl1, phh1;
    logic             v1;
    logic [WIDTH-1:0] pll2, phh2;
    logic [WIDTH:0]   mid2;
    logic             v2;
    logic [2*WIDTH-1:0] sum3;

`ifdef VEDICMULT_SIGNED_EN
    logic neg_in, sg1, sg2;

    // Signed mode feeds magnitudes to the core and remembers the result sign
    always_comb begin
        a_op   = a;
        b_op   = b;
        neg_in = 1'b0;
        if (in_sgn) begin
            a_op   = WIDTH'(mag(MAXW'(a), WIDTH));
            b_op   = WIDTH'(mag(MAXW'(b), WIDTH));
            neg_in = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    // Unsigned build passes operands straight to the core
    always_comb begin
        a_op = a;
        b_op = b;
    end
`endif

    // Whole pipeline advances together unless a held result blocks it
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
    end

    vedicmult_core #(.WIDTH(H)) u_ll (.a(a_op[H-1:0]),     .b(b_op[H-1:0]),     .p(pll_c));
    vedicmult_core #(.WIDTH(H)) u_lh (.a(a_op[H-1:0]),     .b(b_op[WIDTH-1:H]), .p(plh_c));
    vedicmult_core #(.WIDTH(H)) u_hl (.a(a_op[WIDTH-1:H]), .b(b_op[H-1:0]),     .p(phl_c));
    vedicmult_core #(.WIDTH(H)) u_hh (.a(a_op[WIDTH-1:H]), .b(b_op[WIDTH-1:H]), .p(phh_c));

    // Final recombination ahead of the S3 register
    always_comb begin
        sum3 = {phh2, pll2} + ({{(WIDTH-1){1'b0}}, mid2} << H);
    end

    // S1: capture partial products; a bubble enters when in_valid is low
    always_ff @(posedge clk) begin
        if (rst) begin
            pll1 <= '0;
            plh1 <= '0;
            phl1 <= '0;
            phh1 <= '0;
            v1   <= 1'b0;
        end else if (en) begin
            pll1 <= pll_c;
            plh1 <= plh_c;
            phl1 <= phl_c;
            phh1 <= phh_c;
            v1   <= in_valid;
        end
    end

    // S2: crosswise sum, outer products forwarded
    always_ff @(posedge clk) begin
        if (rst) begin
            pll2 <= '0;
            phh2 <= '0;
            mid2 <= '0;
            v2   <= 1'b0;
        end else if (en) begin
            pll2 <= pll1;
            phh2 <= phh1;
            mid2 <= {1'b0, plh1} + {1'b0, phl1};
            v2   <= v1;
        end
    end

`ifdef VEDICMULT_SIGNED_EN
    // Sign bit travels with valid through S1 and S2
    always_ff @(posedge clk) begin
        if (rst) begin
            sg1 <= 1'b0;
            sg2 <= 1'b0;
        end else if (en) begin
            sg1 <= neg_in;
            sg2 <= sg1;
        end
    end

    // S3: product register, negated when the operand signs differed
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out       <= sg2 ? (2*WIDTH)'(negate(MAXW'(sum3), 2*WIDTH)) : sum3;
            out_valid <= v2;
        end
    end
`else
    // S3: product register
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out       <= sum3;
            out_valid <= v2;
        end
    end
`endif

endmodule

// File: tb/tb_vedicmult_pipe.sv
// Self-checking bench for vedicmult_pipe (WIDTH = 8).
// Signed vectors and random signed traffic are included when VEDICMULT_SIGNED_EN is defined.
module tb_vedicmult_pipe;

    localparam int unsigned W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sgn;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           sgn;
        logic [2*W-1:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t strm[$];
    logic [2*W-1:0] sb[$];

    always #5 clk = ~clk;

    vedicmult_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef VEDICMULT_SIGNED_EN
        .in_sgn    (sgn),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    // Reference product straight from integer arithmetic
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int ix, iy, p;
        ix = s ? int'($signed(x)) : int'(x);
        iy = s ? int'($signed(y)) : int'(y);
        p  = ix * iy;
        return p[2*W-1:0];
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        sgn      = s;
    endtask

    logic [2*W-1:0] held;
    logic           stall;
    logic           pred_ready;

    initial begin
        // ---------------- reset with live inputs ----------------
        rst = 1'b1; out_ready = 1'b1;
        drive(8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_out_valid", 16'(out_valid), 16'h0);
            check("reset_out", out, 16'h0);
        end
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_reset_no_result", 16'(out_valid), 16'h0);
        end

        // ---------------- single-op latency, table driven ----------------
        vecs.push_back('{8'hC8, 8'h96, 1'b0, 16'h7530});
        vecs.push_back('{8'h00, 8'hFF, 1'b0, 16'h0000});
        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h80, 8'h02, 1'b0, 16'h0100});
        vecs.push_back('{8'h0F, 8'hF0, 1'b0, 16'h0E10});
`ifdef VEDICMULT_SIGNED_EN
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'hFF, 8'h05, 1'b1, 16'hFFFB});
        vecs.push_back('{8'hFF, 8'h05, 1'b0, 16'h04FB});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});
        vecs.push_back('{8'h00, 8'h80, 1'b1, 16'h0000});
`endif
        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sgn);
            tick();                       // accepted at edge k
            in_valid = 1'b0;
            check("lat_k", 16'(out_valid), 16'h0);
            tick();
            check("lat_k1", 16'(out_valid), 16'h0);
            tick();
            check("lat_k2_valid", 16'(out_valid), 16'h1);
            check("lat_k2_out", out, vecs[i].exp);
            tick();
            check("lat_k3_valid", 16'(out_valid), 16'h0);
        end

        // ---------------- streaming, out_ready held high ----------------
        strm.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        strm.push_back('{8'h00, 8'd37, 1'b0, 16'h0000});
        strm.push_back('{8'h01, 8'h01, 1'b0, 16'h0001});
        strm.push_back('{8'h10, 8'h10, 1'b0, 16'h0100});
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(strm[c].a, strm[c].b, 1'b0);
            else       in_valid = 1'b0;
            tick();
            if (c >= 2) begin
                check("stream_valid", 16'(out_valid), 16'h1);
                check("stream_out", out, strm[c-2].exp);
            end
        end
        tick();
        check("stream_end_valid", 16'(out_valid), 16'h0);

        // ---------------- backpressure ----------------
        drive(8'd3, 8'd5, 1'b0);  tick();
        drive(8'd7, 8'd9, 1'b0);  tick();
        drive(8'd11, 8'd13, 1'b0); tick();
        check("bp_first_valid", 16'(out_valid), 16'h1);
        check("bp_first_out", out, 16'd15);
        out_ready = 1'b0;
        drive(8'hAA, 8'h55, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_in_ready_low", 16'(in_ready), 16'h0);
            tick();
            check("bp_hold_valid", 16'(out_valid), 16'h1);
            check("bp_hold_out", out, 16'd15);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        check("bp_release_ready", 16'(in_ready), 16'h1);
        tick();
        check("bp_r1_valid", 16'(out_valid), 16'h1);
        check("bp_r1_out", out, 16'd63);
        tick();
        check("bp_r2_valid", 16'(out_valid), 16'h1);
        check("bp_r2_out", out, 16'd143);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_no_extra", 16'(out_valid), 16'h0);
        end

        // ---------------- reset mid-operation ----------------
        drive(8'h12, 8'h34, 1'b0); tick();
        drive(8'h56, 8'h78, 1'b0); tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        check("midrst_valid", 16'(out_valid), 16'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_dropped", 16'(out_valid), 16'h0);
        end
        drive(8'h0D, 8'h0B, 1'b0); tick();
        in_valid = 1'b0;
        check("midrst_op_k", 16'(out_valid), 16'h0);
        tick();
        check("midrst_op_k1", 16'(out_valid), 16'h0);
        tick();
        check("midrst_op_valid", 16'(out_valid), 16'h1);
        check("midrst_op_out", out, 16'h008F);
        tick();

        // ---------------- randomized traffic with scoreboard ----------------
        stall = 1'b0;
        held  = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       a = 8'h80;
                1:       a = 8'hFF;
                default: a = W'($urandom);
            endcase
            b = ($urandom_range(0, 5) == 0) ? 8'h00 : W'($urandom);
`ifdef VEDICMULT_SIGNED_EN
            sgn = $urandom_range(0, 1) == 1;
`else
            sgn = 1'b0;
`endif
            #1;
            pred_ready = !out_valid || out_ready;
            check("rand_in_ready", 16'(in_ready), 16'(pred_ready));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand_spurious_result", 16'(out_valid), 16'h0);
                end else begin
                    check("rand_result", out, sb.pop_front());
                end
            end
            if (in_valid && pred_ready) sb.push_back(ref_mul(a, b, sgn));
            stall = out_valid && !out_ready;
            held  = out;
            tick();
            if (stall) begin
                check("rand_stall_valid", 16'(out_valid), 16'h1);
                check("rand_stall_out", out, held);
            end
        end

        // drain with a bounded cycle budget
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() > 0; c++) begin
            #1;
            if (out_valid) check("drain_result", out, sb.pop_front());
            tick();
        end
        check("drain_empty", 16'(sb.size()), 16'h0);
        tick();
        check("drain_idle", 16'(out_valid), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vedicmult_pipe.md
# vedicmult_pipe

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready handshake on both sides. It generalises the 2-bit combinational Vedic multiplier to any power-of-two WIDTH. The product is split into four half-width partial products, recombined with CLA adders across three register stages. It sits between an operand producer and a result consumer, with full backpressure support and one result per clock sustained.

## Interface
- WIDTH, 8, operand width; power of two, ≥ 4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- in_sgn  input  1  operands are two's complement (present only with VEDICMULT_SIGNED_EN).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out  output  2*WIDTH  product.

## Operation
- H = WIDTH/2. aL/aH and bL/bH are the low and high halves of the operands.
- Stage 1 (S1): register the four partial products pLL = aL·bL, pLH = aL·bH, pHL = aH·bL, pHH = aH·bH, each WIDTH bits, plus valid v1.
- Stage 2 (S2): mid = pLH + pHL, WIDTH+1 bits. pLL, pHH and v1 are forwarded as v2.
- Stage 3 (S3): out = {pHH, pLL} + (mid << H), truncated to 2*WIDTH bits (no overflow is possible). out_valid = v3.
- Global advance: en = !out_valid || out_ready. All stages load only when en = 1. in_ready = en, combinational from out_ready.
- Transfer rules:
  - An input is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - If in_valid = 0 while en = 1, a bubble (valid = 0) enters S1.
- Bubbles are not collapsed. The pipeline is a rigid shift.
- No reordering: results leave in acceptance order.
- While out_valid && !out_ready, out and out_valid hold stable. Upstream stages freeze.
- Simultaneous consume-and-accept in one cycle is legal and is the normal streaming case.

## Timing
- Reset: rst sampled high at an edge clears v1/v2/v3 and all data registers to 0. Hence out_valid = 0 and out = 0 the cycle after.
- During reset cycles in_ready = 1, but inputs are discarded.
- Reset mid-operation: in-flight transactions are dropped and never appear at the output.
- Latency: an input accepted at edge k appears at the output with out_valid = 1 right after edge k+2, with no stalls. Each stall cycle adds one cycle.
- Throughput: 1 result per clock while out_ready = 1.
- in_ready depends combinationally on out_ready and out_valid only, never on in_valid.

## Configuration
- Macro VEDICMULT_SIGNED_EN.
- Defined:
  - The in_sgn port exists.
  - With in_sgn = 1, S1 multiplies the magnitudes |a| and |b|. The most-negative value maps to 2^(WIDTH-1), which fits unsigned.
  - The sign bit a[MSB]^b[MSB] is carried through S1–S3 and registered alongside valid. If set, S3 outputs the two's-complement negation of the sum.
  - With in_sgn = 0, behaviour is unsigned, bit-identical to the undefined build.
- Undefined: no in_sgn port; unsigned only; no sign registers.

## Structure
- Shared package/header vedicmult_pkg holds:
  - the LAT = 3 constant;
  - the WIDTH legality check (power of two, ≥ 4), which fails elaboration otherwise;
  - the magnitude/negate helper functions used in the signed build.
- Sub-module vedicmult_core(WIDTH):
  - recursive combinational Vedic multiplier, with the 2-bit multiplier as the base case;
  - instantiated four times at width H in S1.
- CLA adders are inferred or shared from the existing CLA module.

## Test plan
- Reset: rst high for 2 cycles with in_valid = 1, a = 8'hFF, b = 8'hFF. Required: out_valid = 0 and out = 0 throughout, and no result emerges afterwards.
- Single op (WIDTH = 8): a = 8'hC8, b = 8'h96 accepted at edge k. Required: out = 16'h7530 with out_valid = 1 after edge k+2, and out_valid low otherwise.
- Streaming, out_ready = 1: 255·255, 0·37, 1·1, 16·16 on consecutive cycles. Required: 16'hFE01, 16'h0000, 16'h0001, 16'h0100 on 4 consecutive cycles, in order.
- Backpressure: with a result valid, hold out_ready = 0 for 4 cycles while feeding inputs. Required: out stable, in_ready = 0, no inputs accepted. On release, all results emerge in order, with none lost or duplicated.
- Reset mid-operation: accept 2 ops, assert rst at the next edge. Required: neither result ever appears, and a subsequent op returns the correct product at latency 3.
- Signed (macro defined), all with in_sgn = 1 except the last:
  - a = 8'h80, b = 8'h80 → 16'h4000;
  - a = 8'hFF, b = 8'h05 → 16'hFFFB;
  - same operands with in_sgn = 0 → 16'h04FB.
